// File: rtl/lsu_bus_responder_pkg.sv
// Shared types and helpers for the LSU bus responder.
package lsu_bus_responder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } lsu_resp_state_t;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 64;

  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

  // Loads always fetch the whole word; MEM1 selects lanes afterwards.
  function automatic logic [3:0] bus_byte_en(input logic we, input logic [3:0] wsel);
    return we ? wsel : 4'hF;
  endfunction

endpackage

// File: rtl/lsu_bus_responder_if.sv
// LSU request port and data-bus port of the responder, bundled with directional modports.
interface lsu_bus_responder_if;

  logic        lsu_req_i;
  logic [31:0] lsu_addr_i;
  logic        lsu_we_i;
  logic [3:0]  lsu_wsel_byte_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_req_stall_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_req_done_o;
  logic        lsu_err_o;

  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;

  // Handshakes: a request is accepted only in a cycle where the responder is not stalling;
  // the bus address phase completes when bus_req_o & bus_gnt_i, and exactly one
  // bus_rvalid_i follows in a later cycle; lsu_req_done_o is a single-cycle pulse.
  modport slave (
    input  lsu_req_i, lsu_addr_i, lsu_we_i, lsu_wsel_byte_i, lsu_wdata_i,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
    output lsu_req_stall_o, lsu_rdata_o, lsu_req_done_o, lsu_err_o,
    output bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o
  );

  modport master (
    output lsu_req_i, lsu_addr_i, lsu_we_i, lsu_wsel_byte_i, lsu_wdata_i,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
    input  lsu_req_stall_o, lsu_rdata_o, lsu_req_done_o, lsu_err_o,
    input  bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o
  );

endinterface

// File: rtl/lsu_bus_responder_timeout_ctr.sv
// Clearable up-counter flagging expiry after TIMEOUT_CYCLES enabled cycles; 0 disables it.
module lsu_bus_responder_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam bit          ENABLED = (TIMEOUT_CYCLES > 0);
  localparam int unsigned CW      = ENABLED ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST  = ENABLED ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (!ENABLED || clr_i || !en_i) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired_o = ENABLED && en_i && (cnt == LAST);

endmodule

// File: rtl/lsu_bus_responder.sv
// Single-outstanding LSU responder: turns a MEM1 strobe into a bus req/gnt/rvalid transaction.
module lsu_bus_responder
  import lsu_bus_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  lsu_bus_responder_if.slave lsu,
  output lsu_resp_state_t dbg_state_o
);

  lsu_resp_state_t state;
  logic        bus_req_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic accept;
  logic in_wait;
  logic leave;
  logic expired;

  assign accept  = (state == IDLE) && lsu.lsu_req_i;
  assign in_wait = (state != IDLE);
  assign leave   = ((state == REQ) && (lsu.bus_gnt_i || expired)) ||
                   (((state == RESP) || (state == DRAIN)) && (lsu.bus_rvalid_i || expired));

  lsu_bus_responder_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .clr_i    (leave),
    .en_i     (in_wait),
    .expired_o(expired)
  );

  // Payload is captured only on acceptance, so it stays stable while the bus withholds grant.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= word_addr(lsu.lsu_addr_i);
      we_q    <= lsu.lsu_we_i;
      be_q    <= bus_byte_en(lsu.lsu_we_i, lsu.lsu_wsel_byte_i);
      wdata_q <= lsu.lsu_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      bus_req_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu.lsu_req_i) begin
            bus_req_q <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (lsu.bus_gnt_i) begin
            bus_req_q <= 1'b0;
            state     <= RESP;
          end else if (expired) begin
            bus_req_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            state     <= IDLE;
          end
        end
        RESP: begin
          if (lsu.bus_rvalid_i) begin
            done_q <= 1'b1;
            err_q  <= lsu.bus_err_i;
            if (!we_q) rdata_q <= lsu.bus_rdata_i;
            state  <= IDLE;
          end else if (expired) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          // Swallow the late response so it cannot be paired with the next request.
          if (lsu.bus_rvalid_i || expired) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lsu.lsu_req_stall_o = (state != IDLE);
  assign lsu.lsu_rdata_o     = rdata_q;
  assign lsu.lsu_req_done_o  = done_q;
  assign lsu.lsu_err_o       = err_q;
  assign lsu.bus_req_o       = bus_req_q;
  assign lsu.bus_addr_o      = addr_q;
  assign lsu.bus_we_o        = we_q;
  assign lsu.bus_be_o        = be_q;
  assign lsu.bus_wdata_o     = wdata_q;
  assign dbg_state_o         = state;

  a_no_gnt_with_rvalid: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (state == REQ) |-> !(lsu.bus_gnt_i && lsu.bus_rvalid_i));

  a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rstn_i)
    ((state == IDLE) || (state == REQ)) |-> !lsu.bus_rvalid_i);

endmodule

// File: tb/tb_lsu_bus_responder.sv
// Randomised bench for lsu_bus_responder: driver issues LSU/bus traffic, monitor scores responses.
module tb_lsu_bus_responder;
  import lsu_bus_responder_pkg::*;

  localparam int TO = 8;

  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  lsu_resp_state_t dbg_state;

  lsu_bus_responder_if bif ();

  lsu_bus_responder #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .lsu        (bif),
    .dbg_state_o(dbg_state)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // {err, rdata} per completion and {word addr, we, be, wdata} per bus request.
  logic [32:0] exp_q[$];
  logic [68:0] exp_bus_q[$];
  logic [31:0] model_rdata;
  logic        prev_req = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_strobe(input logic we, input logic [31:0] addr, input logic [3:0] wsel,
                              input logic [31:0] wdata);
    bif.lsu_req_i       = 1'b1;
    bif.lsu_we_i        = we;
    bif.lsu_addr_i      = addr;
    bif.lsu_wsel_byte_i = wsel;
    bif.lsu_wdata_i     = wdata;
  endtask

  task automatic push_bus(input logic we, input logic [31:0] addr, input logic [3:0] wsel,
                          input logic [31:0] wdata);
    logic [3:0] be;
    be = we ? wsel : 4'hF;
    exp_bus_q.push_back({addr & 32'hFFFF_FFFC, we, be, wdata});
  endtask

  // g: REQ cycles before grant (>= TO means never), r: RESP cycles before rvalid (>= TO means never).
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] wsel,
                        input logic [31:0] wdata, input int g, input int r,
                        input logic [31:0] rdata, input logic berr,
                        input bit late_rv, input int drain_dly, input bit poke);
    logic exp_err;
    push_bus(we, addr, wsel, wdata);
    if (g >= TO || r >= TO) begin
      exp_err = 1'b1;
    end else begin
      exp_err = berr;
      if (!we) model_rdata = rdata;
    end
    exp_q.push_back({exp_err, model_rdata});

    step();
    drive_strobe(we, addr, wsel, wdata);
    step();
    bif.lsu_req_i = 1'b0;
    check("stall_busy", bif.lsu_req_stall_o, 1'b1);
    if (g >= TO) begin
      repeat (TO) step();
      check("req_timeout_done", {bif.lsu_req_done_o, bif.bus_req_o}, 2'b10);
    end else begin
      repeat (g) step();
      bif.bus_gnt_i = 1'b1;
      step();
      bif.bus_gnt_i = 1'b0;
      if (r >= TO) begin
        repeat (TO) step();
        check("resp_timeout_done", {bif.lsu_req_done_o, bif.lsu_req_stall_o}, 2'b11);
        if (late_rv) begin
          repeat (drain_dly) step();
          bif.bus_rvalid_i = 1'b1;
          bif.bus_rdata_i  = $urandom;
          bif.bus_err_i    = 1'($urandom_range(0, 1));
          step();
          bif.bus_rvalid_i = 1'b0;
        end else begin
          repeat (TO) step();
        end
        check("drain_exit", bif.lsu_req_stall_o, 1'b0);
      end else begin
        for (int i = 0; i < r; i++) begin
          if (poke && i == 0) begin
            drive_strobe(~we, $urandom, 4'h5, $urandom);
            check("stall_resp", bif.lsu_req_stall_o, 1'b1);
          end
          step();
          bif.lsu_req_i = 1'b0;
        end
        bif.bus_rvalid_i = 1'b1;
        bif.bus_rdata_i  = rdata;
        bif.bus_err_i    = berr;
        step();
        bif.bus_rvalid_i = 1'b0;
        bif.bus_err_i    = 1'b0;
        check("done_latency", {bif.lsu_req_done_o, bif.lsu_req_stall_o}, 2'b10);
      end
    end
  endtask

  // Monitor: scores every completion pulse and every cycle of a live bus request.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk_i);
      if (rstn_i) begin
        if (bif.lsu_req_done_o) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected none");
          end else begin
            e = exp_q.pop_front();
            check("done_resp", {bif.lsu_err_o, bif.lsu_rdata_o}, e);
          end
        end
        if (bif.bus_req_o) begin
          if (exp_bus_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_bus_req: got bus_req=1 expected none");
          end else begin
            check("bus_payload", {bif.bus_addr_o, bif.bus_we_o, bif.bus_be_o, bif.bus_wdata_o},
                  exp_bus_q[0]);
          end
        end
      end
      if (prev_req && !bif.bus_req_o && exp_bus_q.size() > 0) void'(exp_bus_q.pop_front());
      prev_req = bif.bus_req_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int r;
    logic we;
    bif.lsu_req_i       = 1'b0;
    bif.lsu_addr_i      = '0;
    bif.lsu_we_i        = 1'b0;
    bif.lsu_wsel_byte_i = '0;
    bif.lsu_wdata_i     = '0;
    bif.bus_gnt_i       = 1'b0;
    bif.bus_rvalid_i    = 1'b0;
    bif.bus_rdata_i     = '0;
    bif.bus_err_i       = 1'b0;
    model_rdata         = '0;

    // Clock/reset
    repeat (3) @(negedge clk_i);
    check("reset_outputs", {bif.lsu_req_stall_o, bif.lsu_rdata_o, bif.lsu_req_done_o, bif.lsu_err_o,
                            bif.bus_req_o, bif.bus_addr_o, bif.bus_we_o, bif.bus_be_o,
                            bif.bus_wdata_o}, '0);
    check("reset_state", dbg_state, IDLE);
    rstn_i = 1'b1;
    step();

    // Directed: minimum-latency load, delayed-grant byte store, busy poke, bus error.
    do_txn(1'b0, 32'h1000_0006, 4'h0, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1'b0);
    do_txn(1'b1, 32'h0000_0003, 4'b1000, 32'hAB00_0000, 5, 2, 32'h1234_5678, 1'b0, 1'b0, 0, 1'b0);
    do_txn(1'b0, 32'h2000_0010, 4'h0, 32'h0, 0, 3, 32'hCAFE_F00D, 1'b0, 1'b0, 0, 1'b1);
    do_txn(1'b0, 32'h3000_0008, 4'h0, 32'h0, 1, 1, 32'h5555_AAAA, 1'b1, 1'b0, 0, 1'b0);

    // Timeouts: no grant; no response with a late discarded rvalid; no response at all.
    do_txn(1'b0, 32'h4000_0000, 4'h0, 32'h0, TO, 0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    do_txn(1'b0, 32'h4000_0004, 4'h0, 32'h0, 0, TO, 32'h0, 1'b0, 1'b1, 2, 1'b0);
    do_txn(1'b0, 32'h4000_0008, 4'h0, 32'h0, 0, 0, 32'h0BAD_CAFE, 1'b0, 1'b0, 0, 1'b0);
    do_txn(1'b1, 32'h4000_000C, 4'b0011, 32'h0000_7777, 2, TO, 32'h0, 1'b0, 1'b0, 0, 1'b0);

    // Reset while waiting for a response: outputs clear at once, late rvalid produces nothing.
    push_bus(1'b0, 32'h5000_0000, 4'h0, 32'h0);
    step();
    drive_strobe(1'b0, 32'h5000_0000, 4'h0, 32'h0);
    step();
    bif.lsu_req_i = 1'b0;
    bif.bus_gnt_i = 1'b1;
    step();
    bif.bus_gnt_i = 1'b0;
    step();
    rstn_i = 1'b0;
    #1;
    check("reset_mid_resp", {bif.lsu_req_stall_o, bif.lsu_rdata_o, bif.lsu_req_done_o, bif.lsu_err_o,
                             bif.bus_req_o, bif.bus_addr_o, bif.bus_we_o, bif.bus_be_o,
                             bif.bus_wdata_o}, '0);
    bif.bus_rvalid_i = 1'b1;
    bif.bus_rdata_i  = 32'hFFFF_0000;
    step();
    bif.bus_rvalid_i = 1'b0;
    step();
    rstn_i = 1'b1;
    model_rdata = '0;
    repeat (3) step();
    check("post_reset_idle", {bif.lsu_req_stall_o, bif.lsu_req_done_o}, 2'b00);

    // Randomised traffic with occasional timeouts.
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom_range(0, 1));
      g  = ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, 3);
      r  = ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, 4);
      do_txn(we, $urandom, we ? 4'($urandom_range(1, 15)) : 4'h0, $urandom, g, r, $urandom,
             ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), $urandom_range(0, TO - 2),
             (r > 0) && ($urandom_range(0, 3) == 0));
    end

    repeat (4) step();
    check("done_queue_empty", exp_q.size(), 0);
    check("bus_queue_empty", exp_bus_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
